// File: rtl/signal_pkg.sv
// signal_pkg
// Shared types and constants for the signal_engine trading decision block.
//   state_t   : decision FSM states (warmup, flat, long)
//   SIDE_BUY  : order_side value for a buy order
//   SIDE_SELL : order_side value for a sell order
package signal_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_FLAT   = 2'd1,
        ST_LONG   = 2'd2
    } state_t;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

endpackage

// File: rtl/cross_detect.sv
// cross_detect
// Tracks whether the fast SMA was above the slow SMA on the previous accepted
// sample and flags crossovers on the current accepted sample.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   accept        : strobe, a sample is consumed this cycle
//   data_5        : fast SMA (unsigned)
//   data_50       : slow SMA (unsigned)
//   golden        : fast crosses above slow on this accepted sample
//   death         : fast crosses to or below slow on this accepted sample
module cross_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [7:0] data_5,
    input  logic [7:0] data_50,
    output logic       golden,
    output logic       death
);

    logic gt;
    logic prev_gt;

    // Equality counts as "not above".
    assign gt = (data_5 > data_50);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_gt <= 1'b0;
        end else if (accept) begin
            prev_gt <= gt;
        end
    end

    assign golden = accept && !prev_gt && gt;
    assign death  = accept && prev_gt && !gt;

endmodule

// File: rtl/signal_engine.sv
// signal_engine
// SMA crossover trading decision engine. After a warmup period it buys on a
// golden cross (volatility permitting) and sells on a death cross, with a
// cooldown between orders, and presents each order on a valid/ready port.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   enable         : sample qualifier
//   data_valid     : preprocessor outputs are valid
//   data_5/data_50 : fast / slow SMA, unsigned
//   sqr_mean       : volatility proxy, unsigned
//   current_data   : latest price, captured as order_price
//   order_valid    : an order is pending
//   order_ready    : downstream accepts the order
//   order_side     : 1 = buy, 0 = sell
//   order_price    : price at the deciding sample
//   position       : 1 = long
//   drop_count     : decisions suppressed by backpressure, saturating
//   fsm_state      : current FSM state (debug observation)
//
// Order handshake: order_valid/order_side/order_price come from registers.
// A transfer happens on a rising edge where order_valid && order_ready.
// While order_valid && !order_ready the payload is held unchanged. A new
// order may load whenever the slot is empty or is being emptied on the same
// edge, so orders can go out back to back. A decision that finds the slot
// full is dropped entirely (no state change, no cooldown) and counted.
module signal_engine
    import signal_pkg::*;
#(
    parameter int          WARMUP    = 200,
    parameter int          COOLDOWN  = 8,
    parameter logic [15:0] VOL_LIMIT = 16'd40000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        data_valid,
    input  logic [7:0]  data_5,
    input  logic [7:0]  data_50,
    input  logic [15:0] sqr_mean,
    input  logic [7:0]  current_data,
    output logic        order_valid,
    input  logic        order_ready,
    output logic        order_side,
    output logic [7:0]  order_price,
    output logic        position,
    output logic [7:0]  drop_count,
    output logic [1:0]  fsm_state
);

    localparam int WW = (WARMUP > 0)   ? $clog2(WARMUP + 1)   : 1;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    state_t          state;
    logic [WW-1:0]   warm_cnt;
    logic [CW-1:0]   cooldown;

    logic accept;
    logic golden;
    logic death;
    logic cd_zero;
    logic want_buy;
    logic want_sell;
    logic decision;
    logic slot_free;

    assign accept = enable && data_valid;

    cross_detect u_cross (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .data_5  (data_5),
        .data_50 (data_50),
        .golden  (golden),
        .death   (death)
    );

    assign cd_zero   = (cooldown == '0);
    // Entries are volatility gated; exits never are.
    assign want_buy  = (state == ST_FLAT) && golden && cd_zero && (sqr_mean <= VOL_LIMIT);
    assign want_sell = (state == ST_LONG) && death && cd_zero;
    assign decision  = want_buy || want_sell;
    assign slot_free = !order_valid || order_ready;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_WARMUP;
            warm_cnt    <= '0;
            cooldown    <= '0;
            drop_count  <= 8'd0;
            order_valid <= 1'b0;
            order_side  <= 1'b0;
            order_price <= 8'd0;
            position    <= 1'b0;
        end else begin
            if (order_valid && order_ready) begin
                order_valid <= 1'b0;
            end

            if (accept) begin
                if (!cd_zero) begin
                    cooldown <= cooldown - CW'(1);
                end

                case (state)
                    ST_WARMUP: begin
                        warm_cnt <= warm_cnt + WW'(1);
                        // Last warmup sample: leave warmup, never trade on it.
                        if (warm_cnt == WW'(WARMUP - 1)) begin
                            state <= ST_FLAT;
                        end
                    end
                    ST_FLAT, ST_LONG: begin
                        if (decision) begin
                            if (slot_free) begin
                                order_valid <= 1'b1;
                                order_side  <= want_buy ? SIDE_BUY : SIDE_SELL;
                                order_price <= current_data;
                                cooldown    <= CW'(COOLDOWN);
                                state       <= want_buy ? ST_LONG : ST_FLAT;
                                position    <= want_buy;
                            end else if (drop_count != 8'hFF) begin
                                drop_count <= drop_count + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_WARMUP;
                        position <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/signal_engine.md
SIGNAL_ENGINE -- requirements
Module: signal_engine

Interface
REQ-001 The block SHALL have parameter WARMUP, default 200: accepted samples required before trading is allowed.
REQ-002 The block SHALL have parameter COOLDOWN, default 8: minimum accepted samples between issued orders.
REQ-003 The block SHALL have parameter VOL_LIMIT, default 16'd40000: entries are blocked when sqr_mean exceeds it.
REQ-004 The block SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst  in  1  asynchronous reset, active-low.
REQ-006 The block SHALL have port enable  in  1  sample qualifier.
REQ-007 The block SHALL have port data_valid  in  1  preprocessor outputs are valid.
REQ-008 The block SHALL have port data_5  in  8  fast SMA, unsigned.
REQ-009 The block SHALL have port data_50  in  8  slow SMA, unsigned.
REQ-010 The block SHALL have port sqr_mean  in  16  squared mean (volatility proxy), unsigned.
REQ-011 The block SHALL have port current_data  in  8  latest price.
REQ-012 The block SHALL have port order_valid  out  1  an order is pending.
REQ-013 The block SHALL have port order_ready  in  1  downstream accepts the order.
REQ-014 The block SHALL have port order_side  out  1  1 = buy, 0 = sell.
REQ-015 The block SHALL have port order_price  out  8  current_data captured at the decision sample.
REQ-016 The block SHALL have port position  out  1  1 = LONG.
REQ-017 The block SHALL have port drop_count  out  8  count of suppressed decisions; saturates at 255.

Function
REQ-018 A sample SHALL be accepted only when enable && data_valid; no other state changes occur except handshake completion.
REQ-019 The FSM SHALL have the states WARMUP, FLAT and LONG; position SHALL be 1 only in LONG.
REQ-020 In WARMUP, a counter SHALL increment on each accepted sample; on the WARMUP-th sample the FSM SHALL go to FLAT, load prev_gt, and issue no order.
REQ-021 gt SHALL be defined as data_5 > data_50 (unsigned); equality SHALL count as not greater; prev_gt SHALL update on every accepted sample in every state.
REQ-022 A golden cross SHALL be !prev_gt && gt, and a death cross SHALL be prev_gt && !gt, both evaluated on an accepted sample.
REQ-023 In FLAT, a golden cross with cooldown==0 and sqr_mean <= VOL_LIMIT SHALL issue a buy and move the FSM to LONG.
REQ-024 In LONG, a death cross with cooldown==0 SHALL issue a sell and move the FSM to FLAT; exits SHALL NOT be volatility-gated.
REQ-025 A cross blocked by cooldown or volatility SHALL be ignored: no state change and no drop_count change.
REQ-026 The cooldown counter SHALL load COOLDOWN when an order is issued, SHALL decrement by 1 per accepted sample, and SHALL saturate at 0.
REQ-027 An order SHALL be registered and SHALL assert order_valid on the cycle after the deciding sample (latency 1).
REQ-028 order_side and order_price SHALL remain stable while order_valid && !order_ready.
REQ-029 A handshake SHALL complete when order_valid && order_ready.
REQ-030 A new order SHALL load if !order_valid || order_ready in the same cycle, which gives back-to-back issue with no bubble.
REQ-031 If a decision occurs while order_valid && !order_ready, the decision SHALL be dropped, the state SHALL NOT change, cooldown SHALL NOT load, and drop_count SHALL increment with saturation.

Reset
REQ-032 On rst low, all of the following SHALL clear asynchronously: FSM to WARMUP; warmup count, cooldown, prev_gt and drop_count to 0; order_valid, order_side, order_price and position to 0.
REQ-033 A reset during a pending order SHALL discard that order; the first post-reset order SHALL require a full warmup.

Structure
REQ-034 Package signal_pkg SHALL hold the state enum (WARMUP/FLAT/LONG) and the constants SIDE_BUY=1 and SIDE_SELL=0.
REQ-035 Sub-module cross_detect SHALL hold prev_gt and produce golden/death pulses from data_5/data_50 and the accept strobe.
REQ-036 Counters SHALL be sized to their parameters: $clog2(WARMUP+1) and $clog2(COOLDOWN+1).

Verification
REQ-037 Warmup: hold data_5=10, data_50=20 for 199 samples, then set data_5=30 -> no order; position=0; the FSM enters FLAT only after the 200th sample.
REQ-038 Buy: after warmup, step data_5 from 10 to 30 (data_50=20, sqr_mean=1000, current_data=25), order_ready=1 -> order_valid high exactly 1 cycle later with side=1, price=25; position=1.
REQ-039 Volatility gate: same golden cross with sqr_mean=50000 -> no order; position=0; drop_count=0.
REQ-040 Backpressure: hold order_ready=0 after a buy, then create a death cross after cooldown expires -> the sell is dropped; drop_count=1; the buy stays stable; position=1.
REQ-041 Cooldown: a buy, then a death cross 3 samples later (COOLDOWN=8) -> ignored; a death cross at sample 9 -> sell issued.
REQ-042 Reset: assert rst low while order_valid=1 and the FSM is LONG -> all outputs go to 0 immediately, without waiting for a clock edge.
